// File: rtl/axis_pkt_fifo_pkg.sv
// Shared definitions for the store-and-forward AXI-Stream packet FIFO.
// Default geometry, derived widths and the write-side state encoding.
package axis_pkt_fifo_pkg;

   localparam int unsigned TDATA_WIDTH_DEF    = 32;
   localparam int unsigned MAX_PKT_LENGTH_DEF = 32;
   localparam int unsigned DEPTH_DEF          = 64;

   localparam int unsigned ADDR_W = $clog2(DEPTH_DEF);
   localparam int unsigned CNT_W  = $clog2(MAX_PKT_LENGTH_DEF) + 1;

   typedef enum logic [0:0] {
      ACCEPT = 1'b0,
      DROP   = 1'b1
   } wr_state_e;

endpackage

// File: rtl/axis_pkt_fifo_ram.sv
// Simple dual-port storage for the packet FIFO: synchronous write, combinational read.
// Each word holds {tlast, tdata}.
module axis_pkt_fifo_ram
   import axis_pkt_fifo_pkg::*;
#(
   parameter int unsigned DW = TDATA_WIDTH_DEF + 1,
   parameter int unsigned AW = ADDR_W
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem_q [2**AW];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO: a packet is released only once its tlast beat is stored.
// Optional oversize-packet dropping is enabled by defining AXIS_PKT_FIFO_DROP_EN.
module axis_pkt_fifo
   import axis_pkt_fifo_pkg::*;
#(
   parameter int unsigned TDATA_WIDTH    = TDATA_WIDTH_DEF,
   parameter int unsigned MAX_PKT_LENGTH = MAX_PKT_LENGTH_DEF,
   parameter int unsigned DEPTH          = DEPTH_DEF
) (
   input  logic                     aclk,
   input  logic                     resetn,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic [TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic                     s_axis_tlast,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
   output logic                     m_axis_tlast,
   output logic [$clog2(DEPTH):0]   o_pkt_cnt,
   output logic [$clog2(DEPTH):0]   o_fill,
   output logic                     o_drop
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW_REQ = $clog2(MAX_PKT_LENGTH) + 1;
   localparam int unsigned CW = (CNT_W > CW_REQ) ? CNT_W : CW_REQ;

   wr_state_e            state_q, state_d;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d, pkt_cnt_q, pkt_cnt_d;
   logic [CW-1:0]        in_cnt_q, in_cnt_d;
   logic                 tvalid_q, tvalid_d, tlast_q, tlast_d, drop_q, drop_d;
   logic [TDATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [TDATA_WIDTH:0] ram_rdata_s;
   logic                 full_s, wr_fire_s, ram_we_s, oversize_s, commit_s, rd_load_s, pkt_dec_s;

   assign full_s    = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);
   assign wr_fire_s = s_axis_tvalid & s_axis_tready;
   assign ram_we_s  = wr_fire_s & (state_q == ACCEPT);

`ifdef AXIS_PKT_FIFO_DROP_EN
   assign oversize_s = ram_we_s & ~s_axis_tlast & (in_cnt_q == CW'(MAX_PKT_LENGTH - 1));
`else
   assign oversize_s = 1'b0;
`endif

   axis_pkt_fifo_ram #(
      .DW (TDATA_WIDTH + 1),
      .AW (AW)
   ) u_ram (
      .clk_i   (aclk),
      .we_i    (ram_we_s),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i ({s_axis_tlast, s_axis_tdata}),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (ram_rdata_s)
   );

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         state_q <= ACCEPT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
`ifdef AXIS_PKT_FIFO_DROP_EN
      case (state_q)
         ACCEPT:  if (oversize_s) state_d = DROP; else state_d = ACCEPT;
         DROP:    if (wr_fire_s && s_axis_tlast) state_d = ACCEPT; else state_d = DROP;
         default: state_d = ACCEPT;
      endcase
`else
      state_d = ACCEPT;
`endif
   end

   // DROP swallows the rest of an oversize packet, so it never back-pressures.
   always_comb begin
      s_axis_tready = 1'b0;
      case (state_q)
         ACCEPT:  s_axis_tready = resetn & ~full_s;
         DROP:    s_axis_tready = resetn;
         default: s_axis_tready = 1'b0;
      endcase
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      wr_commit_d = wr_commit_q;
      in_cnt_d    = in_cnt_q;
      commit_s    = 1'b0;
      drop_d      = 1'b0;
      if (oversize_s) begin
         wr_ptr_d = wr_commit_q;
         in_cnt_d = {CW{1'b0}};
         drop_d   = 1'b1;
      end else if (ram_we_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
         if (s_axis_tlast) begin
            wr_commit_d = wr_ptr_q + PW'(1);
            in_cnt_d    = {CW{1'b0}};
            commit_s    = 1'b1;
         end else begin
            in_cnt_d    = in_cnt_q + CW'(1);
         end
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
   end

   assign rd_load_s = (wr_commit_q != rd_ptr_q) & (~tvalid_q | m_axis_tready);
   assign pkt_dec_s = tvalid_q & m_axis_tready & tlast_q;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      tlast_d  = tlast_q;
      if (rd_load_s) begin
         rd_ptr_d           = rd_ptr_q + PW'(1);
         tvalid_d           = 1'b1;
         {tlast_d, tdata_d} = ram_rdata_s;
      end else if (m_axis_tready) begin
         tvalid_d = 1'b0;
      end else begin
         tvalid_d = tvalid_q;
      end
   end

   always_comb begin
      case ({commit_s, pkt_dec_s})
         2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1);
         2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1);
         default: pkt_cnt_d = pkt_cnt_q;
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         wr_ptr_q    <= {PW{1'b0}};
         wr_commit_q <= {PW{1'b0}};
         rd_ptr_q    <= {PW{1'b0}};
         in_cnt_q    <= {CW{1'b0}};
         pkt_cnt_q   <= {PW{1'b0}};
         tvalid_q    <= 1'b0;
         tdata_q     <= {TDATA_WIDTH{1'b0}};
         tlast_q     <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         wr_commit_q <= wr_commit_d;
         rd_ptr_q    <= rd_ptr_d;
         in_cnt_q    <= in_cnt_d;
         pkt_cnt_q   <= pkt_cnt_d;
         tvalid_q    <= tvalid_d;
         tdata_q     <= tdata_d;
         tlast_q     <= tlast_d;
         drop_q      <= drop_d;
      end
   end

   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tdata  = tdata_q;
   assign m_axis_tlast  = tlast_q;
   assign o_pkt_cnt     = pkt_cnt_q;
   assign o_fill        = wr_ptr_q - rd_ptr_q;
   assign o_drop        = drop_q;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench for axis_pkt_fifo (DEPTH=64, MAX_PKT_LENGTH=32).
// Expectations follow AXIS_PKT_FIFO_DROP_EN when the bundle is built with it.
module tb_axis_pkt_fifo;

   logic        aclk = 1'b0;
   logic        resetn = 1'b0;
   logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
   logic [31:0] s_tdata = 32'd0;
   logic        m_tvalid, m_tready = 1'b0, m_tlast;
   logic [31:0] m_tdata;
   logic [6:0]  pkt_cnt, fill;
   logic        drop;

   logic [32:0] sb[$];
   logic [32:0] exp_w, held_w;
   int n_checks = 0, n_errors = 0, cyc = 0, out_cnt = 0, drop_cnt = 0;
   int pkt_max = 0, gap_cnt = 0, last_out_cyc = 0;
   bit rdy_en = 1'b0, rand_mode = 1'b0, track_gap = 1'b0, have_prev = 1'b0, stall = 1'b0;

`ifdef AXIS_PKT_FIFO_DROP_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   axis_pkt_fifo dut (
      .aclk          (aclk),
      .resetn        (resetn),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .s_axis_tdata  (s_tdata),
      .s_axis_tlast  (s_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tlast  (m_tlast),
      .o_pkt_cnt     (pkt_cnt),
      .o_fill        (fill),
      .o_drop        (drop)
   );

   initial forever #5 aclk = ~aclk;

   initial forever begin
      @(posedge aclk);
      cyc++;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Output-ready driver, changed just after each rising edge.
   initial forever begin
      @(posedge aclk);
      #1;
      m_tready = rand_mode ? ($urandom_range(0, 1) == 1) : rdy_en;
   end

   // Output monitor: scoreboard pop, stall stability, throughput and counter tracking.
   initial forever begin
      @(negedge aclk);
      if (!resetn) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            chk("stall_valid", 64'(m_tvalid), 64'd1);
            chk("stall_hold", 64'({m_tlast, m_tdata}), 64'(held_w));
         end
         if (m_tvalid && m_tready) begin
            out_cnt++;
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               exp_w = sb.pop_front();
               chk("beat", 64'({m_tlast, m_tdata}), 64'(exp_w));
            end
            if (track_gap) begin
               if (have_prev && (cyc - last_out_cyc != 1)) gap_cnt++;
               last_out_cyc = cyc;
               have_prev    = 1'b1;
            end
         end
         stall  = m_tvalid & ~m_tready;
         held_w = {m_tlast, m_tdata};
         if (int'(pkt_cnt) > pkt_max) pkt_max = int'(pkt_cnt);
         if (drop) drop_cnt++;
      end
   end

   task automatic send_beat(input logic [31:0] d, input logic l, input bit push);
      int w;
      s_tvalid = 1'b1;
      s_tdata  = d;
      s_tlast  = l;
      w = 0;
      while (!s_tready && w < 500) begin
         @(negedge aclk);
         w++;
      end
      if (!s_tready) chk("s_ready_timeout", 64'(s_tready), 64'd1);
      else if (push) sb.push_back({l, d});
      @(negedge aclk);
   endtask

   task automatic send_pkt(input int n, input logic [31:0] base, input bit push);
      for (int i = 0; i < n; i++) send_beat(base + 32'(i), (i == n - 1), push);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic wait_drain(input string tag);
      int w;
      w = 0;
      while ((sb.size() != 0 || m_tvalid) && w < 3000) begin
         @(negedge aclk);
         w++;
      end
      chk(tag, 64'(sb.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      repeat (3) @(negedge aclk);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_s_tready", 64'(s_tready), 64'd0);
      chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
      chk("rst_fill", 64'(fill), 64'd0);
      chk("rst_drop", 64'(drop), 64'd0);
      resetn = 1'b1;
      rdy_en = 1'b1;
      @(negedge aclk);
      @(negedge aclk);
      chk("rst_s_tready_up", 64'(s_tready), 64'd1);

      // 1: single 8-beat packet, released one edge after its tlast is stored
      send_pkt(8, 32'd6, 1'b1);
      chk("t1_no_early_valid", 64'(m_tvalid), 64'd0);
      chk("t1_no_early_out", 64'(out_cnt), 64'd0);
      chk("t1_pkt_cnt_1", 64'(pkt_cnt), 64'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge aclk);
         chk("t1_contig_valid", 64'(m_tvalid), 64'd1);
      end
      @(negedge aclk);
      chk("t1_pkt_cnt_0", 64'(pkt_cnt), 64'd0);
      chk("t1_out_count", 64'(out_cnt), 64'd8);

      // 2: fill with output stalled; the output register already holds the first word
      rdy_en = 1'b0;
      repeat (2) @(negedge aclk);
      for (int p = 0; p < 8; p++) send_pkt(8, 32'd1000 + 32'(8 * p), 1'b1);
      chk("t2_fill_63", 64'(fill), 64'd63);
      chk("t2_pkt_cnt_8", 64'(pkt_cnt), 64'd8);
      chk("t2_s_ready_63", 64'(s_tready), 64'd1);
      chk("t2_out_loaded", 64'({m_tvalid, m_tdata}), {31'd0, 1'b1, 32'd1000});
      send_pkt(1, 32'd2000, 1'b1);
      chk("t2_fill_64", 64'(fill), 64'd64);
      chk("t2_full", 64'(s_tready), 64'd0);
      chk("t2_pkt_cnt_9", 64'(pkt_cnt), 64'd9);
      rdy_en = 1'b1;
      wait_drain("t2_drain");
      chk("t2_s_ready_back", 64'(s_tready), 64'd1);
      chk("t2_fill_0", 64'(fill), 64'd0);
      chk("t2_pkt_cnt_0", 64'(pkt_cnt), 64'd0);

      // 3: streaming with pointer wrap
      pkt_max = 0; gap_cnt = 0; have_prev = 1'b0; track_gap = 1'b1;
      for (int p = 0; p < 100; p++) send_pkt(3, 32'd3000 + 32'(3 * p), 1'b1);
      wait_drain("t3_drain");
      track_gap = 1'b0;
      chk("t3_gaps", 64'(gap_cnt), 64'd0);
      chk("t3_pkt_max_le2", 64'(pkt_max <= 2), 64'd1);

      // 4: reset in the middle of a packet
      for (int i = 0; i < 3; i++) send_beat(32'd3900 + 32'(i), 1'b0, 1'b0);
      s_tvalid = 1'b0;
      resetn = 1'b0;
      @(negedge aclk);
      chk("t4_rst_out", 64'({m_tvalid, m_tlast, m_tdata}), 64'd0);
      chk("t4_rst_cnts", 64'({pkt_cnt, fill, drop}), 64'd0);
      chk("t4_rst_s_tready", 64'(s_tready), 64'd0);
      resetn = 1'b1;
      @(negedge aclk);
      send_pkt(4, 32'd4000, 1'b1);
      wait_drain("t4_drain");

      // 5: random backpressure with single-beat packets
      rand_mode = 1'b1;
      base = out_cnt;
      for (int p = 0; p < 40; p++) send_pkt(1, 32'd5000 + 32'(p), 1'b1);
      wait_drain("t5_drain");
      chk("t5_count", 64'(out_cnt - base), 64'd40);
      rand_mode = 1'b0;
      repeat (2) @(negedge aclk);

      // 6: 40-beat packet then a 32-beat packet
      pkt_max = 0;
      base = drop_cnt;
      for (int i = 0; i < 40; i++) begin
         send_beat(32'd6000 + 32'(i), (i == 39), !DROP_EN);
         if (i == 30) chk("t6_no_early_drop", 64'(drop), 64'd0);
         if (i == 31) chk("t6_drop_pulse", 64'(drop), 64'(DROP_EN));
      end
      send_pkt(32, 32'd7000, 1'b1);
      wait_drain("t6_drain");
      chk("t6_drop_count", 64'(drop_cnt - base), 64'(DROP_EN));
      chk("t6_pkt_max", 64'(pkt_max), DROP_EN ? 64'd1 : 64'd2);

      chk("final_sb_empty", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
